// File: rtl/uart_frame_sched.sv
// Round-robin frame scheduler feeding a byte-wide UART transmitter over a uart_data/is_send/is_done handshake.
// Define UART_SCHED_CHKSUM_EN to insert a mod-256 checksum of id and payload before the two tail bytes.
module uart_frame_sched #(
  parameter int unsigned PERIOD = 499999,
  parameter logic [7:0]  HDR    = 8'hAA,
  parameter logic [7:0]  TAIL   = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic [47:0] data_a,
  input  logic        req_b,
  input  logic [95:0] data_b,
  output logic        grant_a,
  output logic        grant_b,
  output logic [7:0]  uart_data,
  output logic        is_send,
  input  logic        is_done,
  output logic        busy
);

`ifdef UART_SCHED_CHKSUM_EN
  localparam int CHK_BYTES = 1;
`else
  localparam int CHK_BYTES = 0;
`endif

  typedef enum logic [2:0] {IDLE, GRANT, LOAD, SEND, GAP} state_t;

  state_t      state;
  logic [31:0] timer;
  logic        timer_wrap;
  logic        tick_pend;
  logic        last_b;
  logic        src_b;
  logic        pick_b;
  logic [95:0] shreg;
  logic [7:0]  id;
  logic [4:0]  idx;
  logic [4:0]  pay_end;
  logic [4:0]  last_idx;
  logic [7:0]  cur_byte;
`ifdef UART_SCHED_CHKSUM_EN
  logic [7:0]  chk;
`endif

  assign timer_wrap = (timer == 32'(PERIOD));

  // With both requests pending, serve the source that was not served last.
  assign pick_b = req_b && (!req_a || !last_b);

  // Byte index layout: 0 header, 1 id, 2..pay_end payload, [checksum], two tails.
  assign pay_end  = src_b ? 5'd13 : 5'd7;
  assign last_idx = pay_end + 5'd2 + 5'(CHK_BYTES);

  always_comb begin
    cur_byte = TAIL;
    if (idx == 5'd0)
      cur_byte = HDR;
    else if (idx == 5'd1)
      cur_byte = id;
    else if (idx <= pay_end)
      cur_byte = shreg[95:88];
`ifdef UART_SCHED_CHKSUM_EN
    else if (idx == pay_end + 5'd1)
      cur_byte = chk;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      timer <= '0;
    else if (timer_wrap)
      timer <= '0;
    else
      timer <= timer + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tick_pend <= 1'b0;
      last_b    <= 1'b1;
      src_b     <= 1'b0;
      grant_a   <= 1'b0;
      grant_b   <= 1'b0;
      uart_data <= '0;
      is_send   <= 1'b0;
      busy      <= 1'b0;
      shreg     <= '0;
      id        <= '0;
      idx       <= '0;
`ifdef UART_SCHED_CHKSUM_EN
      chk       <= '0;
`endif
    end else begin
      grant_a <= 1'b0;
      grant_b <= 1'b0;
      if (timer_wrap)
        tick_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (tick_pend && (req_a || req_b)) begin
            src_b     <= pick_b;
            last_b    <= pick_b;
            grant_a   <= !pick_b;
            grant_b   <= pick_b;
            shreg     <= pick_b ? data_b : {data_a, 48'h0};
            id        <= pick_b ? 8'h02 : 8'h01;
            // A tick landing on the grant cycle itself is kept, not lost.
            tick_pend <= timer_wrap;
            busy      <= 1'b1;
            idx       <= '0;
`ifdef UART_SCHED_CHKSUM_EN
            chk       <= '0;
`endif
            state     <= GRANT;
          end
        end
        GRANT: state <= LOAD;
        LOAD: begin
          uart_data <= cur_byte;
          is_send   <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (is_done) begin
            is_send <= 1'b0;
            state   <= GAP;
          end
        end
        GAP: begin
`ifdef UART_SCHED_CHKSUM_EN
          if (idx >= 5'd1 && idx <= pay_end)
            chk <= chk + uart_data;
`endif
          if (idx >= 5'd2 && idx <= pay_end)
            shreg <= {shreg[87:0], 8'h00};
          if (idx == last_idx) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            idx   <= idx + 5'd1;
            state <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_frame_sched.md
Name: uart_frame_sched

Overview:
Schedules and frames sensor data onto the single byte-wide UART transmitter using its uart_data / is_send / is_done handshake. Two frame sources share the transmitter: A is raw data (3 x 16-bit) and B is filtered data (3 x 32-bit). A period timer paces frames. Pending requests are granted round-robin, and each granted frame is sent as header, ID, payload, optional checksum, then tail.

Parameters:
PERIOD, 499999, frame-period timer terminal count; one tick every PERIOD+1 clk cycles
HDR, 8'hAA, frame header byte
TAIL, 8'hFF, tail byte, sent twice at the end of every frame

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
req_a  in  1  source A has a frame ready (level)
data_a  in  48  {ch1[15:0], ch2[15:0], ch3[15:0]}
req_b  in  1  source B has a frame ready (level)
data_b  in  96  {ch1[31:0], ch2[31:0], ch3[31:0]}
grant_a  out  1  one-cycle pulse: data_a snapshotted
grant_b  out  1  one-cycle pulse: data_b snapshotted
uart_data  out  8  byte to transmit
is_send  out  1  byte valid / transmit request to UART TX
is_done  in  1  one-cycle pulse from UART TX: byte finished
busy  out  1  high from grant until the last tail byte completes

Behaviour:
- Reset (async, rst=0):
  - Outputs: uart_data=0, is_send=0, grant_a=0, grant_b=0, busy=0.
  - Internal: timer=0, tick_pend=0, state=IDLE, round-robin pointer favours A.
- Timer:
  - Free-running 32-bit counter 0..PERIOD.
  - At PERIOD it wraps to 0 and sets tick_pend.
  - tick_pend is a 1-deep flag; ticks that arrive while it is already set are lost.
  - tick_pend is cleared on the grant cycle.
- FSM states: IDLE, GRANT, LOAD, SEND, GAP.
- IDLE:
  - Go to GRANT when tick_pend=1 and (req_a or req_b) are asserted in the same cycle.
  - If no request is asserted, stay in IDLE; tick_pend is held, so the frame starts as soon as a request appears.
- GRANT (1 cycle):
  - Pick the source: if only one request is asserted, that source wins. If both are asserted, the source opposite the last-served source wins.
  - Pulse the matching grant_x, snapshot data_x into the shift register, set id = 8'h01 (A) or 8'h02 (B).
  - Clear tick_pend, set busy=1, reset the checksum accumulator to 0, byte index = 0.
- LOAD (1 cycle): drive uart_data with the current byte, then go to SEND.
- SEND:
  - is_send=1; uart_data is held stable.
  - Wait for is_done=1; on that cycle go to GAP.
- GAP (1 cycle):
  - is_send=0, which guarantees at least one low cycle between bytes.
  - Add the byte just sent to the checksum if it was the ID or a payload byte.
  - Advance the byte index. Next state is LOAD, or IDLE after the final byte (busy=0 on entry to IDLE).
- Byte order:
  - HDR, id, payload MSB-first (A: 6 bytes, B: 12 bytes), [checksum], TAIL, TAIL.
  - Frame length without checksum: A = 10 bytes, B = 16 bytes.
- is_done outside SEND is ignored. Handshake latency from is_done to the next is_send rising edge is exactly 2 cycles (GAP, LOAD).
- req_x may drop after grant_x with no effect on the frame in flight. Source data is sampled only in GRANT.
- Ticks during a frame set tick_pend, so back-to-back frames are allowed.
- Reset mid-frame aborts immediately: is_send falls asynchronously and no partial frame is resumed.

Optional Feature:
UART_SCHED_CHKSUM_EN:
- Defined: a checksum byte is inserted after the payload. Value = 8-bit modulo-256 sum of id and all payload bytes. Frame length becomes A = 11 bytes, B = 17 bytes.
- Undefined: no checksum byte, the accumulator is removed, and frames are 10/16 bytes.

Test Plan:
1. Reset release, PERIOD=20, req_a=0, req_b=0 -> is_send stays 0 and busy=0 for 100 cycles; at req_a rise, grant_a pulses on the next cycle.
2. PERIOD=20, req_a=1, data_a=48'h0F18_37FE_1234, is_done returned 5 cycles after each is_send rise -> byte sequence AA 01 0F 18 37 FE 12 34 A3 FF FF (CHKSUM_EN) or the same without A3; busy drops after the last FF.
3. req_a=1 and req_b=1 held continuously -> frames alternate A, B, A, B; grant pulses alternate; each frame's id matches its grant.
4. is_done pulsed while is_send=0 (during GAP and IDLE) -> ignored; byte index unchanged; no extra byte sent.
5. data_b changed the cycle after grant_b -> transmitted payload equals the snapshot value, not the new value.
6. rst asserted during payload byte 3 of frame B -> is_send=0 and uart_data=0 immediately; after release the next frame starts at HDR with id 01 (pointer favours A).
